stage3_execute: RTL and testbench
=================================

# stage3_execute

EX stage of the 5-stage 16-bit pipelined CPU: holds the ID/EX pipeline register, resolves forwarding from the MEM and WB stages, performs the ALU operation and resolves conditional branches. Its outputs feed the MEM stage's EX/MEM register directly. The block has no memory port.

## Interface
- WORD_SIZE, 16, datapath width (`WORD_SIZE from opcodes.v)
- clk  in  1  clock; all state updates on rising edge
- reset_n  in  1  asynchronous, active-high reset; clears ID/EX register (active-high despite the name)
- Pc  in  16  PC+1 of the instruction in ID
- RegData1, RegData2  in  16  register file reads for Rs and Rt
- Imm  in  16  sign-extended immediate/offset
- Rs, Rt, RegWriteTarget  in  2 each  source and destination register indices
- ALUOp  in  4  operation select (see Operation)
- ALUSrc  in  1  operand B: 1=Imm, 0=forwarded Rt
- BranchType  in  3  0 none, 1 BNE, 2 BEQ, 3 BGZ, 4 BLZ; 5-7 treated as none
- MemRead, MemWrite, RegWrite  in  1 each  control passed through to MEM/WB
- RegWriteSrc  in  2  WB source select, passed through
- Valid  in  1  instruction in ID is real (0 = bubble)
- Stall  in  1  hold ID/EX register
- Flush  in  1  load a bubble into ID/EX
- MEM_RegWrite  in  1; MEM_RegWriteTarget  in  2; MEM_FwdData  in  16  EX/MEM forwarding source
- WB_RegWrite  in  1; WB_RegWriteTarget  in  2; WB_RegWriteData  in  16  MEM/WB forwarding source
- PcVal, ALUOut, StoreData  out  16 each  to MEM stage
- RegWriteTarget_OUT  out  2; MemRead_OUT, MemWrite_OUT, RegWrite_OUT  out  1; RegWriteSrc_OUT  out  2
- BranchTaken  out  1; BranchTarget  out  16  to fetch/hazard unit

## Operation
- ID/EX register holds every input except Stall, Flush and the forwarding ports, plus Valid_REG.
- Update priority at rising edge: reset_n > Flush (Valid_REG←0, all control regs←0, data regs←0) > Stall (hold) > load.
- Forwarding per operand (Rs_REG→A, Rt_REG→fwdB):
  - MEM match (MEM_RegWrite and target equal) wins.
  - Otherwise WB match.
  - Otherwise the registered RegData.
- All four registers are forwardable; there is no hard-wired zero register.
- Operand B = ALUSrc_REG ? Imm_REG : fwdB.
- ALUOp:
  - 0 ADD A+B; 1 SUB A−B; 2 AND; 3 ORR; 4 NOT ~A; 5 TCP −A
  - 6 SHL A<<1; 7 SHR arithmetic A>>>1; 8 LHI {B[7:0],8'h00}; 9 PASS B
  - 10-15 give 0
- Arithmetic is modulo 2^16; overflow and carry are discarded.
- StoreData = fwdB.
- Branch conditions: BNE A≠fwdB; BEQ A=fwdB; BGZ signed A>0; BLZ signed A<0.
- BranchTarget = Pc_REG + Imm_REG, mod 2^16 (0xFFFF+1 wraps to 0x0000).
- Bubble rule: when Valid_REG=0, every output (data, control, BranchTaken, BranchTarget) is 0, regardless of forwarding inputs.

## Timing
- Reset: all outputs 0 immediately (asynchronous) and held while reset_n=1. The first load occurs on the first rising edge after release.
- Latency: values presented at edge N appear on outputs after edge N (combinational from ID/EX plus forwarding ports). The MEM stage captures them at edge N+1.
- Forwarding ports are combinational inputs. A change on MEM_FwdData within a cycle propagates to ALUOut and StoreData in the same cycle.
- Stall held k cycles: outputs stay constant except for forwarding-driven changes.
- Flush and Stall both asserted: Flush wins.
- Reset asserted mid-stall or mid-flush: registers clear at once; no pending state survives.
- BranchTaken is valid in the same cycle the branch occupies EX. The hazard unit uses it to assert Flush on the next edge.

## Test plan
- Reset: reset_n=1 mid-operation -> all outputs 0 immediately; after release, load ADD with RegData1=3, RegData2=4 -> ALUOut=7 after the next edge.
- Forwarding priority: Rs=1; MEM target 1 = 0x0010 and WB target 1 = 0x0020 both asserted -> A=0x0010. Drop MEM_RegWrite -> A=0x0020.
- ALU edges:
  - SUB 0x0000−0x0001 -> 0xFFFF
  - SHR 0x8002 -> 0xC001
  - LHI Imm=0x00AB -> 0xAB00
  - TCP 0x0001 -> 0xFFFF
- Branch: BGZ, A=0x8000 -> BranchTaken=0. BEQ, A=fwdB=5, Pc=0xFFFF, Imm=1 -> BranchTaken=1, BranchTarget=0x0000.
- Stall/Flush: stall 3 cycles -> outputs constant. Flush and Stall together -> next cycle all outputs 0, including RegWrite_OUT.
- Bubble gating: Valid=0 with a matching forward of 0x1234 -> ALUOut=0, StoreData=0.

Source files
------------

// File: rtl/stage3_execute_if.sv
// Bundle between the ID stage, the EX stage and its MEM/WB consumers.
// The slave modport is the EX stage; the master side drives ID/EX inputs and forwarding.
interface stage3_execute_if;
    localparam int WORD_SIZE = 16;

    logic [WORD_SIZE-1:0] Pc;
    logic [WORD_SIZE-1:0] RegData1;
    logic [WORD_SIZE-1:0] RegData2;
    logic [WORD_SIZE-1:0] Imm;
    logic [1:0]           Rs;
    logic [1:0]           Rt;
    logic [1:0]           RegWriteTarget;
    logic [3:0]           ALUOp;
    logic                 ALUSrc;
    logic [2:0]           BranchType;
    logic                 MemRead;
    logic                 MemWrite;
    logic                 RegWrite;
    logic [1:0]           RegWriteSrc;
    logic                 Valid;
    logic                 Stall;
    logic                 Flush;
    logic                 MEM_RegWrite;
    logic [1:0]           MEM_RegWriteTarget;
    logic [WORD_SIZE-1:0] MEM_FwdData;
    logic                 WB_RegWrite;
    logic [1:0]           WB_RegWriteTarget;
    logic [WORD_SIZE-1:0] WB_RegWriteData;

    logic [WORD_SIZE-1:0] PcVal;
    logic [WORD_SIZE-1:0] ALUOut;
    logic [WORD_SIZE-1:0] StoreData;
    logic [1:0]           RegWriteTarget_OUT;
    logic                 MemRead_OUT;
    logic                 MemWrite_OUT;
    logic                 RegWrite_OUT;
    logic [1:0]           RegWriteSrc_OUT;
    logic                 BranchTaken;
    logic [WORD_SIZE-1:0] BranchTarget;

    modport master (
        output Pc, RegData1, RegData2, Imm, Rs, Rt, RegWriteTarget, ALUOp, ALUSrc,
               BranchType, MemRead, MemWrite, RegWrite, RegWriteSrc, Valid, Stall, Flush,
               MEM_RegWrite, MEM_RegWriteTarget, MEM_FwdData,
               WB_RegWrite, WB_RegWriteTarget, WB_RegWriteData,
        input  PcVal, ALUOut, StoreData, RegWriteTarget_OUT, MemRead_OUT, MemWrite_OUT,
               RegWrite_OUT, RegWriteSrc_OUT, BranchTaken, BranchTarget
    );

    modport slave (
        input  Pc, RegData1, RegData2, Imm, Rs, Rt, RegWriteTarget, ALUOp, ALUSrc,
               BranchType, MemRead, MemWrite, RegWrite, RegWriteSrc, Valid, Stall, Flush,
               MEM_RegWrite, MEM_RegWriteTarget, MEM_FwdData,
               WB_RegWrite, WB_RegWriteTarget, WB_RegWriteData,
        output PcVal, ALUOut, StoreData, RegWriteTarget_OUT, MemRead_OUT, MemWrite_OUT,
               RegWrite_OUT, RegWriteSrc_OUT, BranchTaken, BranchTarget
    );
endinterface

// File: rtl/stage3_execute.sv
// EX stage: ID/EX register, MEM/WB operand forwarding, ALU and branch resolution.
// Outputs are combinational from the ID/EX register plus the forwarding ports.
module stage3_execute (
    input  logic            clk,
    input  logic            reset_n,
    stage3_execute_if.slave ex
);
    localparam int WORD_SIZE = 16;
    typedef logic [WORD_SIZE-1:0] word_t;

    typedef struct packed {
        word_t      pc;
        word_t      rd1;
        word_t      rd2;
        word_t      imm;
        logic [1:0] rs;
        logic [1:0] rt;
        logic [1:0] wtgt;
        logic [3:0] alu_op;
        logic       alu_src;
        logic [2:0] br_type;
        logic       mem_read;
        logic       mem_write;
        logic       reg_write;
        logic [1:0] wsrc;
        logic       valid;
    } idex_t;

    localparam idex_t IDEX_BUBBLE = '0;

    idex_t idex_r;
    idex_t idex_load_s;
    word_t op_a_s;
    word_t fwd_b_s;
    word_t op_b_s;
    word_t alu_s;
    logic  taken_s;

    // MEM result is younger than WB, so it wins when both target the same register.
    function automatic word_t forward(input logic [1:0] idx, input word_t reg_val,
                                      input logic mem_rw, input logic [1:0] mem_tgt,
                                      input word_t mem_val, input logic wb_rw,
                                      input logic [1:0] wb_tgt, input word_t wb_val);
        word_t res;
        if (mem_rw && (mem_tgt == idx)) begin
            res = mem_val;
        end else if (wb_rw && (wb_tgt == idx)) begin
            res = wb_val;
        end else begin
            res = reg_val;
        end
        return res;
    endfunction

    // Gather the ID-stage inputs into the register image.
    always_comb begin
        idex_load_s           = IDEX_BUBBLE;
        idex_load_s.pc        = ex.Pc;
        idex_load_s.rd1       = ex.RegData1;
        idex_load_s.rd2       = ex.RegData2;
        idex_load_s.imm       = ex.Imm;
        idex_load_s.rs        = ex.Rs;
        idex_load_s.rt        = ex.Rt;
        idex_load_s.wtgt      = ex.RegWriteTarget;
        idex_load_s.alu_op    = ex.ALUOp;
        idex_load_s.alu_src   = ex.ALUSrc;
        idex_load_s.br_type   = ex.BranchType;
        idex_load_s.mem_read  = ex.MemRead;
        idex_load_s.mem_write = ex.MemWrite;
        idex_load_s.reg_write = ex.RegWrite;
        idex_load_s.wsrc      = ex.RegWriteSrc;
        idex_load_s.valid     = ex.Valid;
    end

    // ID/EX register: reset, then flush, then stall, then load.
    always_ff @(posedge clk or posedge reset_n) begin
        if (reset_n) begin
            idex_r <= IDEX_BUBBLE;
        end else if (ex.Flush) begin
            idex_r <= IDEX_BUBBLE;
        end else if (!ex.Stall) begin
            idex_r <= idex_load_s;
        end
    end

    // Operand forwarding, ALU and branch condition.
    always_comb begin
        op_a_s  = forward(idex_r.rs, idex_r.rd1, ex.MEM_RegWrite, ex.MEM_RegWriteTarget,
                          ex.MEM_FwdData, ex.WB_RegWrite, ex.WB_RegWriteTarget,
                          ex.WB_RegWriteData);
        fwd_b_s = forward(idex_r.rt, idex_r.rd2, ex.MEM_RegWrite, ex.MEM_RegWriteTarget,
                          ex.MEM_FwdData, ex.WB_RegWrite, ex.WB_RegWriteTarget,
                          ex.WB_RegWriteData);
        op_b_s  = idex_r.alu_src ? idex_r.imm : fwd_b_s;
        alu_s   = 16'h0000;
        taken_s = 1'b0;
        case (idex_r.alu_op)
            4'd0:    alu_s = op_a_s + op_b_s;
            4'd1:    alu_s = op_a_s - op_b_s;
            4'd2:    alu_s = op_a_s & op_b_s;
            4'd3:    alu_s = op_a_s | op_b_s;
            4'd4:    alu_s = ~op_a_s;
            4'd5:    alu_s = 16'h0000 - op_a_s;
            4'd6:    alu_s = {op_a_s[14:0], 1'b0};
            4'd7:    alu_s = {op_a_s[15], op_a_s[15:1]};
            4'd8:    alu_s = {op_b_s[7:0], 8'h00};
            4'd9:    alu_s = op_b_s;
            default: alu_s = 16'h0000;
        endcase
        case (idex_r.br_type)
            3'd1:    taken_s = (op_a_s != fwd_b_s);
            3'd2:    taken_s = (op_a_s == fwd_b_s);
            3'd3:    taken_s = !op_a_s[15] && (op_a_s != 16'h0000);
            3'd4:    taken_s = op_a_s[15];
            default: taken_s = 1'b0;
        endcase
    end

    // A bubble in EX presents all-zero outputs, whatever the forwarding ports carry.
    always_comb begin
        ex.PcVal              = 16'h0000;
        ex.ALUOut             = 16'h0000;
        ex.StoreData          = 16'h0000;
        ex.RegWriteTarget_OUT = 2'b00;
        ex.MemRead_OUT        = 1'b0;
        ex.MemWrite_OUT       = 1'b0;
        ex.RegWrite_OUT       = 1'b0;
        ex.RegWriteSrc_OUT    = 2'b00;
        ex.BranchTaken        = 1'b0;
        ex.BranchTarget       = 16'h0000;
        if (idex_r.valid) begin
            ex.PcVal              = idex_r.pc;
            ex.ALUOut             = alu_s;
            ex.StoreData          = fwd_b_s;
            ex.RegWriteTarget_OUT = idex_r.wtgt;
            ex.MemRead_OUT        = idex_r.mem_read;
            ex.MemWrite_OUT       = idex_r.mem_write;
            ex.RegWrite_OUT       = idex_r.reg_write;
            ex.RegWriteSrc_OUT    = idex_r.wsrc;
            ex.BranchTaken        = taken_s;
            ex.BranchTarget       = idex_r.pc + idex_r.imm;
        end else begin
            ex.BranchTaken        = 1'b0;
        end
    end
endmodule

// File: tb/tb_stage3_execute.sv
// Directed bench for stage3_execute: stimulus pushes hand-computed expectations,
// a negedge monitor pops and compares them against the EX outputs.
module tb_stage3_execute;
    logic clk;
    logic reset_n;
    int   errors = 0;
    int   checks = 0;

    stage3_execute_if bus ();

    stage3_execute dut (
        .clk     (clk),
        .reset_n (reset_n),
        .ex      (bus.slave)
    );

    typedef struct {
        string       name;
        logic [15:0] alu;
        logic [15:0] store;
        logic [15:0] pcval;
        logic        bt;
        logic [15:0] btgt;
        logic        rw;
        logic        mr;
        logic        mw;
        logic [1:0]  tgt;
        logic [1:0]  src;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic exp_t mk(input string name, input logic [15:0] alu,
                                input logic [15:0] store, input logic [15:0] pcval,
                                input logic bt, input logic [15:0] btgt, input logic rw,
                                input logic mr, input logic mw, input logic [1:0] tgt,
                                input logic [1:0] src);
        exp_t e;
        e.name = name; e.alu = alu; e.store = store; e.pcval = pcval; e.bt = bt;
        e.btgt = btgt; e.rw = rw; e.mr = mr; e.mw = mw; e.tgt = tgt; e.src = src;
        return e;
    endfunction

    function automatic exp_t zero(input string name);
        return mk(name, 16'h0000, 16'h0000, 16'h0000, 1'b0, 16'h0000,
                  1'b0, 1'b0, 1'b0, 2'd0, 2'd0);
    endfunction

    task automatic chk(input string name, input string field,
                       input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s.%s: got %h expected %h", name, field, act, exp);
        end
    endtask

    always @(negedge clk) begin
        while (q.size() > 0) begin
            mon_e = q.pop_front();
            chk(mon_e.name, "ALUOut",       bus.ALUOut,                   mon_e.alu);
            chk(mon_e.name, "StoreData",    bus.StoreData,                mon_e.store);
            chk(mon_e.name, "PcVal",        bus.PcVal,                    mon_e.pcval);
            chk(mon_e.name, "BranchTaken",  {15'd0, bus.BranchTaken},     {15'd0, mon_e.bt});
            chk(mon_e.name, "BranchTarget", bus.BranchTarget,             mon_e.btgt);
            chk(mon_e.name, "RegWrite",     {15'd0, bus.RegWrite_OUT},    {15'd0, mon_e.rw});
            chk(mon_e.name, "MemRead",      {15'd0, bus.MemRead_OUT},     {15'd0, mon_e.mr});
            chk(mon_e.name, "MemWrite",     {15'd0, bus.MemWrite_OUT},    {15'd0, mon_e.mw});
            chk(mon_e.name, "WrTarget",     {14'd0, bus.RegWriteTarget_OUT}, {14'd0, mon_e.tgt});
            chk(mon_e.name, "WrSrc",        {14'd0, bus.RegWriteSrc_OUT}, {14'd0, mon_e.src});
        end
    end

    task automatic set_id(input logic [15:0] pc, input logic [15:0] rd1, input logic [15:0] rd2,
                          input logic [15:0] imm, input logic [1:0] rs, input logic [1:0] rt,
                          input logic [1:0] wtgt, input logic [3:0] op, input logic alusrc,
                          input logic [2:0] btype, input logic mr, input logic mw,
                          input logic rw, input logic [1:0] src, input logic valid);
        bus.Pc = pc; bus.RegData1 = rd1; bus.RegData2 = rd2; bus.Imm = imm;
        bus.Rs = rs; bus.Rt = rt; bus.RegWriteTarget = wtgt; bus.ALUOp = op;
        bus.ALUSrc = alusrc; bus.BranchType = btype; bus.MemRead = mr; bus.MemWrite = mw;
        bus.RegWrite = rw; bus.RegWriteSrc = src; bus.Valid = valid;
    endtask

    task automatic set_fwd(input logic mrw, input logic [1:0] mt, input logic [15:0] md,
                           input logic wrw, input logic [1:0] wt, input logic [15:0] wd);
        bus.MEM_RegWrite = mrw; bus.MEM_RegWriteTarget = mt; bus.MEM_FwdData = md;
        bus.WB_RegWrite = wrw; bus.WB_RegWriteTarget = wt; bus.WB_RegWriteData = wd;
    endtask

    // One clock: edge, expectation queued, monitor compares at the following negedge.
    task automatic cyc(input exp_t e);
        @(posedge clk);
        #1;
        q.push_back(e);
        @(negedge clk);
        #1;
    endtask

    // Raise reset mid-cycle and expect outputs to clear before any edge.
    task automatic rst_check(input string name);
        reset_n = 1'b1;
        #1;
        q.push_back(zero(name));
        @(negedge clk);
        #1;
    endtask

    task automatic alu_case(input string name, input logic [3:0] op, input logic [15:0] a,
                            input logic [15:0] b, input logic [15:0] expv);
        set_id(16'h0000, a, b, 16'h0000, 2'd0, 2'd1, 2'd3, op, 1'b0, 3'd0,
               1'b0, 1'b0, 1'b1, 2'd0, 1'b1);
        cyc(mk(name, expv, b, 16'h0000, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 2'd3, 2'd0));
    endtask

    task automatic br_case(input string name, input logic [2:0] btype, input logic [15:0] a,
                           input logic [15:0] b, input logic [15:0] pc, input logic [15:0] imm,
                           input logic taken, input logic [15:0] alu, input logic [15:0] tgt);
        set_id(pc, a, b, imm, 2'd0, 2'd1, 2'd0, 4'd0, 1'b0, btype,
               1'b0, 1'b0, 1'b0, 2'd0, 1'b1);
        cyc(mk(name, alu, b, pc, taken, tgt, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0));
    endtask

    initial begin
        reset_n = 1'b1;
        bus.Stall = 1'b0;
        bus.Flush = 1'b0;
        set_fwd(1'b0, 2'd0, 16'h0000, 1'b0, 2'd0, 16'h0000);
        set_id(16'h0010, 16'h0003, 16'h0004, 16'h0005, 2'd0, 2'd1, 2'd2, 4'd0, 1'b0, 3'd0,
               1'b0, 1'b0, 1'b1, 2'd1, 1'b1);
        rst_check("reset_hold");
        reset_n = 1'b0;
        cyc(mk("add_after_reset", 16'h0007, 16'h0004, 16'h0010, 1'b0, 16'h0015,
               1'b1, 1'b0, 1'b0, 2'd2, 2'd1));
        rst_check("reset_mid_op");
        reset_n = 1'b0;
        cyc(mk("add_reload", 16'h0007, 16'h0004, 16'h0010, 1'b0, 16'h0015,
               1'b1, 1'b0, 1'b0, 2'd2, 2'd1));

        // Forwarding priority on operand A, then on Rt.
        set_fwd(1'b1, 2'd1, 16'h0010, 1'b1, 2'd1, 16'h0020);
        set_id(16'h0100, 16'h0005, 16'h0007, 16'h0000, 2'd1, 2'd2, 2'd1, 4'd0, 1'b1, 3'd0,
               1'b0, 1'b0, 1'b1, 2'd0, 1'b1);
        cyc(mk("fwd_mem_wins", 16'h0010, 16'h0007, 16'h0100, 1'b0, 16'h0100,
               1'b1, 1'b0, 1'b0, 2'd1, 2'd0));
        set_fwd(1'b0, 2'd1, 16'h0010, 1'b1, 2'd1, 16'h0020);
        cyc(mk("fwd_wb", 16'h0020, 16'h0007, 16'h0100, 1'b0, 16'h0100,
               1'b1, 1'b0, 1'b0, 2'd1, 2'd0));
        set_fwd(1'b0, 2'd1, 16'h0010, 1'b0, 2'd1, 16'h0020);
        cyc(mk("fwd_none", 16'h0005, 16'h0007, 16'h0100, 1'b0, 16'h0100,
               1'b1, 1'b0, 1'b0, 2'd1, 2'd0));
        set_fwd(1'b1, 2'd2, 16'h0033, 1'b0, 2'd0, 16'h0000);
        cyc(mk("fwd_rt", 16'h0005, 16'h0033, 16'h0100, 1'b0, 16'h0100,
               1'b1, 1'b0, 1'b0, 2'd1, 2'd0));
        set_fwd(1'b0, 2'd0, 16'h0000, 1'b0, 2'd0, 16'h0000);

        alu_case("add",  4'd0,  16'hFFFF, 16'h0002, 16'h0001);
        alu_case("sub",  4'd1,  16'h0000, 16'h0001, 16'hFFFF);
        alu_case("and",  4'd2,  16'h0F0F, 16'h00FF, 16'h000F);
        alu_case("orr",  4'd3,  16'h0F0F, 16'h00FF, 16'h0FFF);
        alu_case("not",  4'd4,  16'h00F0, 16'h0001, 16'hFF0F);
        alu_case("tcp",  4'd5,  16'h0001, 16'h0001, 16'hFFFF);
        alu_case("shl",  4'd6,  16'h8001, 16'h0001, 16'h0002);
        alu_case("shr",  4'd7,  16'h8002, 16'h0001, 16'hC001);
        alu_case("pass", 4'd9,  16'h1111, 16'h5A5A, 16'h5A5A);
        alu_case("op12", 4'd12, 16'h1234, 16'h4321, 16'h0000);
        set_id(16'h0000, 16'h1111, 16'h0001, 16'h00AB, 2'd0, 2'd1, 2'd3, 4'd8, 1'b1, 3'd0,
               1'b0, 1'b0, 1'b1, 2'd0, 1'b1);
        cyc(mk("lhi", 16'hAB00, 16'h0001, 16'h0000, 1'b0, 16'h00AB,
               1'b1, 1'b0, 1'b0, 2'd3, 2'd0));

        br_case("bgz_neg",  3'd3, 16'h8000, 16'h0000, 16'h0020, 16'h0004, 1'b0, 16'h8000, 16'h0024);
        br_case("beq_wrap", 3'd2, 16'h0005, 16'h0005, 16'hFFFF, 16'h0001, 1'b1, 16'h000A, 16'h0000);
        br_case("bne_eq",   3'd1, 16'h0005, 16'h0005, 16'h0010, 16'hFFFE, 1'b0, 16'h000A, 16'h000E);
        br_case("bne_ne",   3'd1, 16'h0005, 16'h0006, 16'h0010, 16'h0002, 1'b1, 16'h000B, 16'h0012);
        br_case("blz_neg",  3'd4, 16'h8000, 16'h0000, 16'h0000, 16'h0000, 1'b1, 16'h8000, 16'h0000);
        br_case("bgz_pos",  3'd3, 16'h0001, 16'h0000, 16'h0000, 16'h0000, 1'b1, 16'h0001, 16'h0000);
        br_case("bgz_zero", 3'd3, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 1'b0, 16'h0000, 16'h0000);
        br_case("br_rsvd",  3'd6, 16'h0005, 16'h0006, 16'h0000, 16'h0000, 1'b0, 16'h000B, 16'h0000);

        // BEQ on a forwarded r0 value: no hard-wired zero register.
        set_fwd(1'b1, 2'd0, 16'h0002, 1'b0, 2'd0, 16'h0000);
        set_id(16'h0030, 16'h0001, 16'h0002, 16'h0000, 2'd0, 2'd1, 2'd0, 4'd0, 1'b0, 3'd2,
               1'b0, 1'b0, 1'b0, 2'd0, 1'b1);
        cyc(mk("beq_fwd_r0", 16'h0004, 16'h0002, 16'h0030, 1'b1, 16'h0030,
               1'b0, 1'b0, 1'b0, 2'd0, 2'd0));
        set_fwd(1'b0, 2'd0, 16'h0000, 1'b0, 2'd0, 16'h0000);

        // Stall holds the register while ID inputs change; forwarding still acts.
        set_id(16'h0040, 16'h0100, 16'h0011, 16'h0002, 2'd1, 2'd2, 2'd0, 4'd0, 1'b0, 3'd0,
               1'b0, 1'b1, 1'b0, 2'd0, 1'b1);
        cyc(mk("stall_load", 16'h0111, 16'h0011, 16'h0040, 1'b0, 16'h0042,
               1'b0, 1'b0, 1'b1, 2'd0, 2'd0));
        bus.Stall = 1'b1;
        set_id(16'h9999, 16'h9999, 16'h9999, 16'h9999, 2'd3, 2'd3, 2'd3, 4'd1, 1'b1, 3'd1,
               1'b1, 1'b0, 1'b1, 2'd3, 1'b1);
        for (int k = 0; k < 3; k++) begin
            cyc(mk("stall_hold", 16'h0111, 16'h0011, 16'h0040, 1'b0, 16'h0042,
                   1'b0, 1'b0, 1'b1, 2'd0, 2'd0));
        end
        set_fwd(1'b1, 2'd2, 16'h0022, 1'b0, 2'd0, 16'h0000);
        cyc(mk("stall_fwd", 16'h0122, 16'h0022, 16'h0040, 1'b0, 16'h0042,
               1'b0, 1'b0, 1'b1, 2'd0, 2'd0));
        bus.MEM_FwdData = 16'h0023;
        cyc(mk("stall_fwd_chg", 16'h0123, 16'h0023, 16'h0040, 1'b0, 16'h0042,
               1'b0, 1'b0, 1'b1, 2'd0, 2'd0));
        set_fwd(1'b0, 2'd0, 16'h0000, 1'b0, 2'd0, 16'h0000);
        bus.Flush = 1'b1;
        cyc(zero("flush_and_stall"));
        bus.Flush = 1'b0;
        bus.Stall = 1'b0;

        // Bubble gating versus the same instruction marked valid.
        set_fwd(1'b1, 2'd1, 16'h1234, 1'b1, 2'd1, 16'h1234);
        set_id(16'h0050, 16'h0001, 16'h0002, 16'h0003, 2'd1, 2'd1, 2'd2, 4'd0, 1'b0, 3'd2,
               1'b1, 1'b1, 1'b1, 2'd2, 1'b0);
        cyc(zero("bubble"));
        bus.Valid = 1'b1;
        cyc(mk("bubble_valid", 16'h2468, 16'h1234, 16'h0050, 1'b1, 16'h0053,
               1'b1, 1'b1, 1'b1, 2'd2, 2'd2));

        // Reset during a stall and during a flush leaves nothing behind.
        bus.Stall = 1'b1;
        rst_check("reset_mid_stall");
        reset_n = 1'b0;
        cyc(zero("stall_after_reset"));
        bus.Stall = 1'b0;
        cyc(mk("reload_after_stall", 16'h2468, 16'h1234, 16'h0050, 1'b1, 16'h0053,
               1'b1, 1'b1, 1'b1, 2'd2, 2'd2));
        bus.Flush = 1'b1;
        rst_check("reset_mid_flush");
        reset_n = 1'b0;
        bus.Flush = 1'b0;

        @(negedge clk);
        #1;
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
